ff_reg_rr_arbiter: RTL and testbench

//  Shares one WIDTH-bit register (async active-low reset D flip-flops)

---
 rtl/ff_reg_rr_arbiter.sv | 103 ++++++++++
 tb/tb_ff_reg_rr_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ff_reg_rr_arbiter.sv
// Round-robin shared register: NUM_REQ writers, one 3-cycle grant/ack write each.
// Optional ARB_LOCK_EN: a locking owner keeps top priority for the next arbitration.
module ff_reg_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    localparam int IDW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     reset_al_in,
    input  logic [NUM_REQ-1:0]       req_in,
    input  logic [NUM_REQ*WIDTH-1:0] data_in,
    input  logic [NUM_REQ-1:0]       lock_in,
    output logic [NUM_REQ-1:0]       gnt_out,
    output logic                     ack_out,
    output logic [IDW-1:0]           owner_out,
    output logic                     busy_out,
    output logic [WIDTH-1:0]         q_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        ACK   = 2'd2
    } state_t;

    state_t         state;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] pick;
    logic [IDW-1:0] idx;
    logic [IDW-1:0] ptr_next;
    logic           found;

    // Cyclic scan starting at the pointer; first requester found wins.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = IDW'((int'(ptr) + i) % NUM_REQ);
            if (!found && req_in[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    assign ptr_next = (int'(owner_out) == NUM_REQ - 1) ? '0 : owner_out + IDW'(1);

`ifndef ARB_LOCK_EN
    logic lock_unused;
    assign lock_unused = ^lock_in;
`endif

    always_ff @(posedge clk or negedge reset_al_in) begin
        if (!reset_al_in) begin
            state     <= IDLE;
            ptr       <= '0;
            gnt_out   <= '0;
            ack_out   <= 1'b0;
            owner_out <= '0;
            busy_out  <= 1'b0;
            q_out     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    gnt_out <= '0;
                    ack_out <= 1'b0;
                    if (found) begin
                        gnt_out   <= NUM_REQ'(1) << pick;
                        owner_out <= pick;
                        busy_out  <= 1'b1;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    // Commit regardless of whether the owner still requests.
                    q_out   <= data_in[int'(owner_out)*WIDTH +: WIDTH];
                    gnt_out <= '0;
                    ack_out <= 1'b1;
                    ptr     <= ptr_next;
                    state   <= ACK;
                end
                ACK: begin
                    ack_out  <= 1'b0;
                    busy_out <= 1'b0;
                    state    <= IDLE;
`ifdef ARB_LOCK_EN
                    if (lock_in[owner_out]) begin
                        ptr <= owner_out;
                    end
`endif
                end
                default: begin
                    gnt_out  <= '0;
                    ack_out  <= 1'b0;
                    busy_out <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ff_reg_rr_arbiter.sv
// Randomized self-checking bench for ff_reg_rr_arbiter against a behavioural round-robin model.
module tb_ff_reg_rr_arbiter;
    logic        clk;
    logic        reset_al_in;
    logic [3:0]  req_in;
    logic [31:0] data_in;
    logic [3:0]  lock_in;
    logic [3:0]  gnt_out;
    logic        ack_out;
    logic [1:0]  owner_out;
    logic        busy_out;
    logic [7:0]  q_out;

    int checks = 0;
    int errors = 0;

    int         m_ptr   = 0;
    int         m_owner = 0;
    logic [7:0] m_q     = 8'h00;

    ff_reg_rr_arbiter #(.NUM_REQ(4), .WIDTH(8)) dut (
        .clk(clk), .reset_al_in(reset_al_in), .req_in(req_in), .data_in(data_in),
        .lock_in(lock_in), .gnt_out(gnt_out), .ack_out(ack_out), .owner_out(owner_out),
        .busy_out(busy_out), .q_out(q_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int model_pick(input logic [3:0] req);
        for (int i = 0; i < 4; i++) begin
            if (req[(m_ptr + i) % 4]) return (m_ptr + i) % 4;
        end
        return -1;
    endfunction

    function automatic void model_reset();
        m_ptr   = 0;
        m_owner = 0;
        m_q     = 8'h00;
    endfunction

    // One full arbitration attempt starting in IDLE; returns the granted index or -1.
    task automatic txn(input string tag, input logic [3:0] req, input logic [31:0] data,
                       input logic [3:0] lock, input bit churn, output int k);
        logic [3:0] exp_gnt;
        req_in  = req;
        data_in = data;
        lock_in = lock;
        k = model_pick(req);
        tick();
        if (k < 0) begin
            checks++;
            if (gnt_out !== 4'b0 || busy_out !== 1'b0 || ack_out !== 1'b0 || q_out !== m_q
                || owner_out !== 2'(m_owner)) begin
                errors++;
                $display("FAIL %s idle: gnt=%b busy=%b ack=%b q=%h owner=%0d, required gnt=0000 busy=0 ack=0 q=%h owner=%0d",
                         tag, gnt_out, busy_out, ack_out, q_out, owner_out, m_q, m_owner);
            end
            return;
        end
        exp_gnt = 4'b0001 << k;
        checks++;
        if (gnt_out !== exp_gnt || owner_out !== 2'(k) || busy_out !== 1'b1 || ack_out !== 1'b0
            || q_out !== m_q) begin
            errors++;
            $display("FAIL %s grant: gnt=%b owner=%0d busy=%b ack=%b q=%h, required gnt=%b owner=%0d busy=1 ack=0 q=%h",
                     tag, gnt_out, owner_out, busy_out, ack_out, q_out, exp_gnt, k, m_q);
        end
        if (churn) req_in = 4'($urandom_range(0, 15));
        tick();
        m_q     = data[k*8 +: 8];
        m_owner = k;
        m_ptr   = (k + 1) % 4;
        checks++;
        if (q_out !== m_q || ack_out !== 1'b1 || gnt_out !== 4'b0 || busy_out !== 1'b1) begin
            errors++;
            $display("FAIL %s ack: q=%h ack=%b gnt=%b busy=%b, required q=%h ack=1 gnt=0000 busy=1",
                     tag, q_out, ack_out, gnt_out, busy_out, m_q);
        end
        if (churn) req_in = 4'($urandom_range(0, 15));
        tick();
`ifdef ARB_LOCK_EN
        if (lock_in[k]) m_ptr = k;
`endif
        checks++;
        if (q_out !== m_q || ack_out !== 1'b0 || gnt_out !== 4'b0 || busy_out !== 1'b0) begin
            errors++;
            $display("FAIL %s done: q=%h ack=%b gnt=%b busy=%b, required q=%h ack=0 gnt=0000 busy=0",
                     tag, q_out, ack_out, gnt_out, busy_out, m_q);
        end
    endtask

    task automatic idle_inputs();
        req_in  = 4'b0;
        lock_in = 4'b0;
    endtask

    task automatic check_zero(input string tag);
        checks++;
        if (q_out !== 8'h00 || gnt_out !== 4'b0 || ack_out !== 1'b0 || owner_out !== 2'd0
            || busy_out !== 1'b0) begin
            errors++;
            $display("FAIL %s: q=%h gnt=%b ack=%b owner=%0d busy=%b, required all zero",
                     tag, q_out, gnt_out, ack_out, owner_out, busy_out);
        end
    endtask

    task automatic test_reset();
        int k;
        #12;
        check_zero("reset_initial");
        reset_al_in = 1'b1;
        model_reset();
        txn("reset_pre", 4'b0100, 32'h00C30000, 4'b0, 1'b0, k);
        #2;
        reset_al_in = 1'b0;
        #1;
        check_zero("reset_midcycle");
        #1;
        reset_al_in = 1'b1;
        model_reset();
    endtask

    task automatic test_single();
        int k;
        idle_inputs();
        txn("single_req2", 4'b0100, 32'h00A50000, 4'b0, 1'b0, k);
        idle_inputs();
        tick();
    endtask

    task automatic test_back_to_back();
        int k;
        int exp_seq[5] = '{0, 1, 2, 3, 0};
        model_reset();
        reset_al_in = 1'b0;
        #1;
        reset_al_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            txn("b2b", 4'b1111, 32'h13121110, 4'b0, 1'b0, k);
            checks++;
            if (owner_out !== 2'(exp_seq[i]) || q_out !== 8'(8'h10 + exp_seq[i])) begin
                errors++;
                $display("FAIL b2b_seq[%0d]: owner=%0d q=%h, required owner=%0d q=%h",
                         i, owner_out, q_out, exp_seq[i], 8'(8'h10 + exp_seq[i]));
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_in_grant();
        int k;
        txn("rst_grant_pre", 4'b0010, 32'h00003300, 4'b0, 1'b0, k);
        req_in  = 4'b0010;
        data_in = 32'h00007700;
        tick();
        #2;
        reset_al_in = 1'b0;
        #1;
        check_zero("rst_in_grant");
        #1;
        reset_al_in = 1'b1;
        model_reset();
        txn("rst_rearb", 4'b1010, 32'h88001100, 4'b0, 1'b0, k);
        idle_inputs();
        tick();
    endtask

    task automatic test_lock();
        int k;
        int exp_seq[3];
`ifdef ARB_LOCK_EN
        exp_seq = '{0, 0, 0};
`else
        exp_seq = '{0, 1, 0};
`endif
        reset_al_in = 1'b0;
        #1;
        reset_al_in = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            txn("lock", 4'b0011, 32'h0000BBAA, 4'b0001, 1'b0, k);
            checks++;
            if (owner_out !== 2'(exp_seq[i])) begin
                errors++;
                $display("FAIL lock_seq[%0d]: owner=%0d, required %0d", i, owner_out, exp_seq[i]);
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_wrap();
        int k;
        txn("wrap_req3", 4'b1000, 32'h5A000000, 4'b0, 1'b0, k);
        txn("wrap_next", 4'b1001, 32'h6B00004C, 4'b0, 1'b0, k);
        checks++;
        if (owner_out !== 2'd0 || q_out !== 8'h4C) begin
            errors++;
            $display("FAIL wrap_to_0: owner=%0d q=%h, required owner=0 q=4c", owner_out, q_out);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_random();
        int k;
        for (int i = 0; i < 60; i++) begin
            txn("random", 4'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)),
                1'b1, k);
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        reset_al_in = 1'b0;
        req_in      = 4'b0;
        data_in     = 32'b0;
        lock_in     = 4'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_reset_in_grant();
        test_lock();
        test_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
